// File: rtl/bist_response_checker.sv
// BIST response checker: compacts a stream of result words into a MISR and
// compares the final signature against a golden value latched at start.
module bist_response_checker #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned N_VECTORS = 16,
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] SEED      = 32'hFFFFFFFF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [WIDTH-1:0]               expected_sig_i,
  input  logic                           valid_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           pass_o,
  output logic                           timeout_o,
  output logic [WIDTH-1:0]               signature_o,
  output logic [$clog2(N_VECTORS+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(N_VECTORS + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] POLY_W   = WIDTH'(POLY);
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [CW-1:0]    LAST_CNT = CW'(N_VECTORS - 1);
  localparam logic [IW-1:0]    LAST_IDL = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q;
  logic             busy_q, done_q, pass_q, timeout_q;
  logic [WIDTH-1:0] sig_q, exp_q, misr_d;
  logic [CW-1:0]    count_q;
  logic [IW-1:0]    idle_q;

  // Shift left, fold the outgoing MSB back through the polynomial, then mix in the word.
  always_comb begin
    misr_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY_W : '0) ^ data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      sig_q     <= '0;
      exp_q     <= '0;
      count_q   <= '0;
      idle_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q   <= S_COLLECT;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            sig_q     <= SEED_W;
            exp_q     <= expected_sig_i;
            count_q   <= '0;
            idle_q    <= '0;
          end
        end
        S_COLLECT: begin
          if (valid_i) begin
            sig_q   <= misr_d;
            count_q <= count_q + CW'(1);
            idle_q  <= '0;
            if (count_q == LAST_CNT) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= (misr_d == exp_q);
              timeout_q <= 1'b0;
            end
          end else begin
            idle_q <= idle_q + IW'(1);
            // A word on the threshold cycle takes the branch above, so it wins.
            if (idle_q == LAST_IDL) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign signature_o = sig_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_bist_response_checker.sv
// Self-checking bench for bist_response_checker: table vectors, directed
// corner sequences and randomized runs against a signature-folding model.
module tb_bist_response_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, valid;
  logic [31:0] exp_sig, data;

  logic a_busy, a_done, a_pass, a_to; logic [31:0] a_sig; logic [2:0] a_cnt;
  logic b_busy, b_done, b_pass, b_to; logic [31:0] b_sig; logic [0:0] b_cnt;
  logic c_busy, c_done, c_pass, c_to; logic [31:0] c_sig; logic [0:0] c_cnt;
  logic d_busy, d_done, d_pass, d_to; logic [31:0] d_sig; logic [1:0] d_cnt;

  // A: timeout/random runs; B, C: single-word with zero/default seed; D: two words, zero seed.
  bist_response_checker #(.WIDTH(32), .N_VECTORS(4), .POLY(POLY), .SEED(SEED), .TIMEOUT(4)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .expected_sig_i(exp_sig), .valid_i(valid),
    .data_i(data), .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_to),
    .signature_o(a_sig), .count_o(a_cnt));
  bist_response_checker #(.WIDTH(32), .N_VECTORS(1), .POLY(POLY), .SEED(32'h0), .TIMEOUT(8)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .expected_sig_i(exp_sig), .valid_i(valid),
    .data_i(data), .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_to),
    .signature_o(b_sig), .count_o(b_cnt));
  bist_response_checker #(.WIDTH(32), .N_VECTORS(1), .POLY(POLY), .SEED(SEED), .TIMEOUT(8)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .expected_sig_i(exp_sig), .valid_i(valid),
    .data_i(data), .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass), .timeout_o(c_to),
    .signature_o(c_sig), .count_o(c_cnt));
  bist_response_checker #(.WIDTH(32), .N_VECTORS(2), .POLY(POLY), .SEED(32'h0), .TIMEOUT(8)) u_d (
    .clk_i(clk), .rst_i(rst), .start_i(start), .expected_sig_i(exp_sig), .valid_i(valid),
    .data_i(data), .busy_o(d_busy), .done_o(d_done), .pass_o(d_pass), .timeout_o(d_to),
    .signature_o(d_sig), .count_o(d_cnt));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Signature as polynomial arithmetic: multiply by x modulo P, then add the word.
  function automatic logic [31:0] mulx(input logic [31:0] s);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ {1'b1, POLY};
    return t[31:0];
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] seed, input logic [31:0] w[$], input int n);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = mulx(s) ^ w[i];
    return s;
  endfunction

  typedef struct {
    logic [31:0] exp;
    logic [31:0] data;
    logic [31:0] b_sig;
    logic        b_pass;
    logic [31:0] c_sig;
    logic        c_pass;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [31:0] w[$];
    logic [31:0] good, e, held_sig;
    logic [2:0]  held_cnt;
    int          gap[4];
    int          n;
    bit          timed;

    tbl[0] = '{32'h12345678, 32'h12345678, 32'h12345678, 1'b1, 32'hE90AB431, 1'b0};
    tbl[1] = '{32'hFB3EE249, 32'h00000000, 32'h00000000, 1'b0, 32'hFB3EE249, 1'b1};
    tbl[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 32'hFB3EE249, 1'b0};
    tbl[3] = '{32'hE90AB431, 32'h12345678, 32'h12345678, 1'b0, 32'hE90AB431, 1'b1};

    rst = 1'b1; start = 1'b0; valid = 1'b0; exp_sig = '0; data = '0;
    step();
    step();
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_pass", 32'(a_pass), 0);
    chk("rst_timeout", 32'(a_to), 0);
    chk("rst_sig", a_sig, 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    rst = 1'b0;

    // Single-word table; expected_sig_i is scrambled after start to prove it is latched.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      start = 1'b1; exp_sig = tbl[i].exp;
      step();
      start = 1'b0; exp_sig = ~tbl[i].exp;
      chk("tbl_b_busy", 32'(b_busy), 1);
      chk("tbl_b_seed", b_sig, 0);
      chk("tbl_c_busy", 32'(c_busy), 1);
      chk("tbl_c_seed", c_sig, SEED);
      valid = 1'b1; data = tbl[i].data;
      step();
      valid = 1'b0;
      chk("tbl_b_state", 32'({b_done, b_busy, b_to}), 32'b100);
      chk("tbl_b_sig", b_sig, tbl[i].b_sig);
      chk("tbl_b_pass", 32'(b_pass), 32'(tbl[i].b_pass));
      chk("tbl_b_cnt", 32'(b_cnt), 1);
      chk("tbl_c_state", 32'({c_done, c_busy, c_to}), 32'b100);
      chk("tbl_c_sig", c_sig, tbl[i].c_sig);
      chk("tbl_c_pass", 32'(c_pass), 32'(tbl[i].c_pass));
      chk("tbl_c_cnt", 32'(c_cnt), 1);
    end

    // Reset mid-COLLECT, then valid pulses must be ignored in IDLE.
    do_reset();
    start = 1'b1; exp_sig = 32'hDEADBEEF;
    step();
    start = 1'b0; valid = 1'b1; data = $urandom;
    step();
    valid = 1'b0;
    chk("mid_cnt", 32'(a_cnt), 1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("mid_rst_state", 32'({a_busy, a_done, a_pass, a_to}), 0);
    chk("mid_rst_sig", a_sig, 0);
    chk("mid_rst_cnt", 32'(a_cnt), 0);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin data = $urandom; step(); end
    valid = 1'b0;
    chk("idle_valid_cnt", 32'(a_cnt), 0);
    chk("idle_valid_busy", 32'(a_busy), 0);

    // start during COLLECT ignored; a word on the 4th idle cycle beats the timeout.
    w = {};
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    start = 1'b1;
    step();
    start = 1'b0; valid = 1'b1; data = w[0];
    step();
    start = 1'b1; data = w[1];
    step();
    start = 1'b0; valid = 1'b0;
    chk("coll_start_cnt", 32'(a_cnt), 2);
    chk("coll_start_sig", a_sig, fold(SEED, w, 2));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap3_busy", 32'({a_done, a_busy}), 1);
    end
    valid = 1'b1; data = w[2];
    step();
    valid = 1'b0;
    chk("gap3_word_cnt", 32'(a_cnt), 3);
    chk("gap3_word_state", 32'({a_done, a_busy, a_to}), 32'b010);
    for (int i = 0; i < 3; i++) step();
    chk("to_not_yet", 32'(a_done), 0);
    step();
    chk("to_state", 32'({a_done, a_busy, a_to, a_pass}), 32'b1010);
    chk("to_cnt", 32'(a_cnt), 3);
    chk("to_sig", a_sig, fold(SEED, w, 3));
    held_sig = a_sig;
    valid = 1'b1;
    for (int i = 0; i < 2; i++) begin data = $urandom; step(); end
    valid = 1'b0;
    chk("done_hold_sig", a_sig, held_sig);
    chk("done_hold_state", 32'({a_done, a_to, a_cnt}), {27'd0, 2'b11, 3'd3});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_state", 32'({a_done, a_busy}), 1);
    chk("restart_sig", a_sig, SEED);
    chk("restart_cnt", 32'(a_cnt), 0);

    // Two words with a 3-cycle gap, zero seed.
    do_reset();
    start = 1'b1; exp_sig = 32'h04C11DB7;
    step();
    start = 1'b0; valid = 1'b1; data = 32'h80000000;
    step();
    valid = 1'b0;
    chk("two_first_sig", d_sig, 32'h80000000);
    for (int i = 0; i < 3; i++) step();
    chk("two_gap_busy", 32'(d_busy), 1);
    valid = 1'b1; data = 32'h00000000;
    step();
    valid = 1'b0;
    chk("two_cnt", 32'(d_cnt), 2);
    chk("two_sig", d_sig, 32'h04C11DB7);
    chk("two_state", 32'({d_done, d_pass, d_to}), 32'b110);

    // Randomized runs: back-to-back restarts from DONE, random gaps incl. timeouts.
    do_reset();
    for (int r = 0; r < 40; r++) begin
      w = {};
      for (int k = 0; k < 4; k++) begin
        w.push_back($urandom);
        gap[k] = ($urandom_range(0, 7) == 0) ? 4 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      end
      good = fold(SEED, w, 4);
      e = ($urandom_range(0, 1) == 1) ? good : good ^ (32'h1 << $urandom_range(0, 31));
      start = 1'b1; exp_sig = e;
      step();
      start = 1'b0; exp_sig = $urandom;
      chk("rnd_start_state", 32'({a_done, a_busy}), 1);
      chk("rnd_start_sig", a_sig, SEED);
      timed = 1'b0; n = 0;
      for (int k = 0; k < 4 && !timed; k++) begin
        for (int j = 0; j < gap[k]; j++) begin
          valid = 1'b0; data = $urandom;
          step();
          if (j == 3) begin timed = 1'b1; break; end
          chk("rnd_idle_state", 32'({a_done, a_busy}), 1);
        end
        if (!timed) begin
          valid = 1'b1; data = w[k];
          step();
          valid = 1'b0;
          n++;
          if (n < 4) chk("rnd_word_state", 32'({a_done, a_busy}), 1);
        end
      end
      chk("rnd_end_state", 32'({a_done, a_busy}), 32'b10);
      chk("rnd_timeout", 32'(a_to), 32'(timed));
      chk("rnd_pass", 32'(a_pass), (!timed && good == e) ? 1 : 0);
      chk("rnd_cnt", 32'(a_cnt), n);
      chk("rnd_sig", a_sig, fold(SEED, w, n));
      held_sig = a_sig; held_cnt = a_cnt;
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        valid = 1'(($urandom_range(0, 1))); data = $urandom;
        step();
        valid = 1'b0;
        chk("rnd_hold", 32'({a_done, a_cnt}), {28'd0, 1'b1, held_cnt});
        chk("rnd_hold_sig", a_sig, held_sig);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
